// File: rtl/fb_read_dma.sv
// fb_read_dma: framebuffer read DMA. Issues incrementing AXI3 read bursts over a
// programmable frame region and forwards R beats straight to the video FIFO.
// Pacing is a credit window that is charged at issue and drained by consume_pixel.
// Optional macro FB_READ_DMA_UNDERRUN_EN adds a saturating underrun counter.
module fb_read_dma #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CREDIT_MAX = 64,
  parameter int unsigned CNT_W      = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [ADDR_W-1:0]                 cfg_base,
  input  logic [CNT_W-1:0]                  cfg_words,
  output logic [ADDR_W-1:0]                 m_araddr,
  output logic [3:0]                        m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  input  logic                              m_rvalid,
  input  logic [DATA_W-1:0]                 m_rdata,
  output logic                              m_rready,
  output logic [DATA_W-1:0]                 fifo_data,
  output logic                              fifo_en,
  input  logic                              fifo_rdy,
  input  logic                              consume_pixel,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(CREDIT_MAX+1)-1:0]   credits
`ifdef FB_READ_DMA_UNDERRUN_EN
  ,
  input  logic                              underrun_clr,
  output logic [15:0]                       underrun_cnt
`endif
);

  localparam int unsigned CRED_W   = $clog2(CREDIT_MAX + 1);
  localparam int unsigned SUM_W    = CRED_W + 1;
  localparam int unsigned BL_W     = $clog2(BURST_LEN + 1);
  localparam int unsigned SIZE_LOG = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, GAP, ADDR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   remaining;

  logic [BL_W-1:0]    blen_c;
  logic               issue_c;
  logic               last_c;
  logic [CNT_W-1:0]   cfg_len_c;
  logic [CRED_W-1:0]  cred_add_c;
  logic [CRED_W-1:0]  cred_next_c;
  logic [ADDR_W-1:0]  addr_step_c;

  // R channel is a pure wire-through; no storage on the data path
  assign m_rready  = fifo_rdy;
  assign fifo_data = m_rdata;
  assign fifo_en   = m_rvalid;

  assign m_arsize  = 3'(SIZE_LOG);
  assign m_arburst = 2'b01;

  // Burst sizing, issue decision and combined credit update
  always_comb begin
    blen_c      = (remaining >= CNT_W'(BURST_LEN)) ? BL_W'(BURST_LEN) : BL_W'(remaining);
    issue_c     = (state == GAP) && enable &&
                  ((SUM_W'(credits) + SUM_W'(blen_c)) <= SUM_W'(CREDIT_MAX));
    last_c      = (remaining == CNT_W'(blen_c));
    cfg_len_c   = (cfg_words == '0) ? CNT_W'(1) : cfg_words;
    addr_step_c = ADDR_W'(blen_c) << SIZE_LOG;
    cred_add_c  = credits + (issue_c ? CRED_W'(blen_c) : CRED_W'(0));
    cred_next_c = cred_add_c;
    if (consume_pixel && (cred_add_c != '0)) begin
      cred_next_c = cred_add_c - CRED_W'(1);
    end
  end

  // Burst sequencer: IDLE -> GAP (wait for credit room) -> ADDR (hold until accepted)
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m_araddr   <= '0;
      m_arlen    <= '0;
      m_arvalid  <= 1'b0;
      remaining  <= '0;
      credits    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      credits    <= cred_next_c;
      unique case (state)
        IDLE: begin
          if (enable) begin
            m_araddr  <= cfg_base;
            remaining <= cfg_len_c;
            busy      <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (issue_c) begin
            m_arvalid <= 1'b1;
            m_arlen   <= 4'(blen_c - BL_W'(1));
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            if (last_c) begin
              // Frame end: reload from live cfg so a new base takes effect here
              frame_done <= 1'b1;
              m_araddr   <= cfg_base;
              remaining  <= cfg_len_c;
            end else begin
              m_araddr   <= m_araddr + addr_step_c;
              remaining  <= remaining - CNT_W'(blen_c);
            end
            if (enable) begin
              state <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          m_arvalid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef FB_READ_DMA_UNDERRUN_EN
  // Saturating count of pixels consumed while no credit was outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end else if (consume_pixel && (credits == '0) && busy && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_read_dma.sv
// tb_fb_read_dma: directed plus random stimulus against a cycle-level reference
// model of the burst/credit rules for fb_read_dma.
module tb_fb_read_dma;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] cfg_base;
  logic [23:0] cfg_words;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_rready;
  logic [31:0] fifo_data;
  logic        fifo_en;
  logic        fifo_rdy;
  logic        consume_pixel;
  logic        busy;
  logic        frame_done;
  logic [6:0]  credits;
`ifdef FB_READ_DMA_UNDERRUN_EN
  logic        underrun_clr;
  logic [15:0] underrun_cnt;
`endif

  fb_read_dma dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_base(cfg_base), .cfg_words(cfg_words),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_rready(m_rready), .fifo_data(fifo_data), .fifo_en(fifo_en), .fifo_rdy(fifo_rdy),
    .consume_pixel(consume_pixel), .busy(busy), .frame_done(frame_done), .credits(credits)
`ifdef FB_READ_DMA_UNDERRUN_EN
    , .underrun_clr(underrun_clr), .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 stopped, 1 waiting for credit room, 2 request outstanding
  int          ph = 0;
  int          mrem = 0;
  int          mcred = 0;
  int          munder = 0;
  bit          mfd = 1'b0;
  logic [31:0] maddr = '0;

  // Observations used by directed steps
  int          hs_cnt = 0;
  int          fd_cnt = 0;
  logic [31:0] hs_addr[$];
  logic [3:0]  hs_len[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    hs_cnt = 0;
    fd_cnt = 0;
    hs_addr.delete();
    hs_len.delete();
  endtask

  // One clock: predict from current inputs, advance, compare outputs
  task automatic step();
    int len;
    bit issue;
    int nc;
    int nph;
    bit nfd;
    int nu;
    #1;
    check("pass_rready", 64'(m_rready), 64'(fifo_rdy));
    check("pass_data",   64'(fifo_data), 64'(m_rdata));
    check("pass_en",     64'(fifo_en), 64'(m_rvalid));
    if (m_arvalid && m_arready) begin
      hs_cnt++;
      hs_addr.push_back(m_araddr);
      hs_len.push_back(m_arlen);
    end
    len   = (mrem > 16) ? 16 : mrem;
    issue = (ph == 1) && enable && (mcred + len <= 64);
    nc    = mcred + (issue ? len : 0);
    if (consume_pixel && nc > 0) nc--;
    nu = munder;
`ifdef FB_READ_DMA_UNDERRUN_EN
    if (underrun_clr) nu = 0;
    else if (consume_pixel && mcred == 0 && ph != 0 && munder < 65535) nu = munder + 1;
`endif
    nfd = 1'b0;
    nph = ph;
    case (ph)
      0: if (enable) begin
        maddr = cfg_base;
        mrem  = (cfg_words == 0) ? 1 : int'(cfg_words);
        nph   = 1;
      end
      1: if (!enable) nph = 0; else if (issue) nph = 2;
      default: if (m_arready) begin
        if (mrem == len) begin
          nfd   = 1'b1;
          maddr = cfg_base;
          mrem  = (cfg_words == 0) ? 1 : int'(cfg_words);
        end else begin
          maddr = maddr + 32'(4 * len);
          mrem  = mrem - len;
        end
        nph = enable ? 1 : 0;
      end
    endcase
    if (rst) begin
      nph = 0; nc = 0; nfd = 1'b0; nu = 0; maddr = '0; mrem = 0;
    end
    ph = nph; mcred = nc; mfd = nfd; munder = nu;
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    check("arvalid",    64'(m_arvalid), 64'(ph == 2));
    check("busy",       64'(busy), 64'(ph != 0));
    check("frame_done", 64'(frame_done), 64'(mfd));
    check("credits",    64'(credits), 64'(mcred));
    if (ph == 2) begin
      len = (mrem > 16) ? 16 : mrem;
      check("araddr", 64'(m_araddr), 64'(maddr));
      check("arlen",  64'(m_arlen), 64'(len - 1));
    end
`ifdef FB_READ_DMA_UNDERRUN_EN
    check("underrun_cnt", 64'(underrun_cnt), 64'(munder));
`endif
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_base = '0; cfg_words = 24'd1;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; fifo_rdy = 1'b0; consume_pixel = 1'b0;
`ifdef FB_READ_DMA_UNDERRUN_EN
    underrun_clr = 1'b0;
`endif
    step();
    step();
    check("rst_araddr", 64'(m_araddr), 64'h0);
    check("rst_credits", 64'(credits), 64'h0);
    check("arsize", 64'(m_arsize), 64'h2);
    check("arburst", 64'(m_arburst), 64'h1);
    rst = 1'b0;

    // Full 64-word frame with no consumption fills the credit window exactly
    cfg_base = 32'h1000_0000; cfg_words = 24'd64; m_arready = 1'b1; enable = 1'b1;
    clear_log();
    repeat (30) step();
    check("t1_bursts", 64'(hs_cnt), 64'd4);
    for (int i = 0; i < 4 && i < hs_addr.size(); i++) begin
      check("t1_addr", 64'(hs_addr[i]), 64'(32'h1000_0000 + 32'(64 * i)));
      check("t1_len", 64'(hs_len[i]), 64'd15);
    end
    check("t1_credits", 64'(credits), 64'd64);

    // 40-word frame: 16+16+8, then wrap back to base
    cfg_words = 24'd40;
    reset_pulse();
    clear_log();
    repeat (30) step();
    check("t2_bursts", 64'(hs_cnt), 64'd4);
    if (hs_len.size() >= 4) begin
      check("t2_len0", 64'(hs_len[0]), 64'd15);
      check("t2_len1", 64'(hs_len[1]), 64'd15);
      check("t2_len2", 64'(hs_len[2]), 64'd7);
      check("t2_wrap", 64'(hs_addr[3]), 64'h1000_0000);
    end
    check("t2_fd", 64'(fd_cnt), 64'd1);

    // Base switched mid-frame only takes effect at the frame boundary
    reset_pulse();
    clear_log();
    repeat (3) step();
    cfg_base = 32'h2000_0000;
    repeat (25) step();
    if (hs_addr.size() >= 4) begin
      check("t3_old", 64'(hs_addr[2]), 64'h1000_0080);
      check("t3_new", 64'(hs_addr[3]), 64'h2000_0000);
    end else check("t3_bursts", 64'(hs_cnt), 64'd4);

    // Issue and consume in one cycle: 48 + 16 - 1
    cfg_base = 32'h3000_0000; cfg_words = 24'd48;
    reset_pulse();
    repeat (7) step();
    check("t4_c48", 64'(credits), 64'd48);
    consume_pixel = 1'b1;
    step();
    consume_pixel = 1'b0;
    check("t4_c63", 64'(credits), 64'd63);

    // Consume with zero credits saturates; underrun counts only while busy
    enable = 1'b0;
    reset_pulse();
    consume_pixel = 1'b1;
    repeat (3) step();
    check("t4_c0", 64'(credits), 64'd0);
    enable = 1'b1;
    step();
    step();
    check("t4_c15", 64'(credits), 64'd15);
`ifdef FB_READ_DMA_UNDERRUN_EN
    check("t4_under1", 64'(underrun_cnt), 64'd1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("t4_underclr", 64'(underrun_cnt), 64'd0);
`endif
    consume_pixel = 1'b0;

    // Address stall with enable dropped mid-stall
    cfg_base = 32'h4000_0000; cfg_words = 24'd64; m_arready = 1'b0;
    reset_pulse();
    repeat (2) step();
    check("t5_valid", 64'(m_arvalid), 64'd1);
    repeat (5) step();
    enable = 1'b0;
    repeat (5) step();
    check("t5_addr", 64'(m_araddr), 64'h4000_0000);
    check("t5_len", 64'(m_arlen), 64'd15);
    m_arready = 1'b1;
    step();
    repeat (4) step();
    check("t5_idle_busy", 64'(busy), 64'd0);
    check("t5_idle_valid", 64'(m_arvalid), 64'd0);

    // Reset while a request is outstanding
    m_arready = 1'b0; enable = 1'b1;
    repeat (3) step();
    check("t6_valid", 64'(m_arvalid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid0", 64'(m_arvalid), 64'd0);
    check("t6_cred0", 64'(credits), 64'd0);
    check("t6_busy0", 64'(busy), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 15) != 0);
      m_arready     = ($urandom_range(0, 2) != 0);
      consume_pixel = ($urandom_range(0, 2) == 0);
      m_rvalid      = $urandom_range(0, 1) != 0;
      m_rdata       = $urandom;
      fifo_rdy      = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 63) == 0) cfg_words = 24'($urandom_range(0, 50));
      if ($urandom_range(0, 63) == 0) cfg_base = $urandom & 32'hFFFF_FFFC;
      rst = ($urandom_range(0, 499) == 0);
`ifdef FB_READ_DMA_UNDERRUN_EN
      underrun_clr = ($urandom_range(0, 99) == 0);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
